mu02_core: RTL and testbench

Parametrised successor to the MU01 accumulator processor: a two-phase (fetch/execute) accumulator machine with width-generic datapath, on-chip unified program/data memory with a load port, signed-correct flags (Z/N/C/V), logical instructions, illegal-opcode trap, explicit start/halt control and a retired-instruction counter. It sits at the top of the simple-processor hierarchy; a testbench or loader fills memory, pulses `start`, and observes state through the status ports.

---
 rtl/mu02_core.sv | 173 +++++++++++++++++
 tb/tb_mu02_core.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mu02_core.sv
// mu02_core: two-phase (fetch/execute) accumulator machine with unified memory,
// load port, Z/N/C/V flags, illegal-opcode trap and retired-instruction counter.
module mu02_core #(
    parameter int OPND_W = 12,
    parameter int CNT_W  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  load_en,
    input  logic [OPND_W-1:0]     load_addr,
    input  logic [OPND_W+3:0]     load_data,
    output logic                  halted,
    output logic                  illegal,
    output logic [OPND_W-1:0]     pc,
    output logic [OPND_W+3:0]     acc,
    output logic [3:0]            flags,
    output logic [CNT_W-1:0]      retired
);
    // state | meaning
    // IDLE  | after reset; load port open, waiting for start
    // FETCH | ir <= mem[pc], pc advances
    // EXEC  | execute ir, back to FETCH unless halting
    // HALT  | stopped by STP or trap; load port open, waiting for start

    localparam int DW    = OPND_W + 4;
    localparam int DEPTH = 1 << OPND_W;

    localparam logic [3:0] OP_LDA  = 4'h0;
    localparam logic [3:0] OP_STO  = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_JMP  = 4'h4;
    localparam logic [3:0] OP_JGE  = 4'h5;
    localparam logic [3:0] OP_JNE  = 4'h6;
    localparam logic [3:0] OP_STP  = 4'h7;
    localparam logic [3:0] OP_LDAI = 4'h8;
    localparam logic [3:0] OP_ADDI = 4'hA;
    localparam logic [3:0] OP_SUBI = 4'hB;
    localparam logic [3:0] OP_AND  = 4'hC;
    localparam logic [3:0] OP_OR   = 4'hD;

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_HALT} state_t;

    state_t                state, state_nx;
    logic [DW-1:0]         mem [DEPTH];
    logic [DW-1:0]         ir;
    logic [3:0]            opcode;
    logic [OPND_W-1:0]     op;
    logic [DW-1:0]         simm, mem_rd, opnd_b;
    logic [DW:0]           add_res;
    logic [DW-1:0]         sub_res;
    logic                  add_ovf, sub_ovf, sub_borrow;

    logic [OPND_W-1:0]     pc_nx;
    logic [DW-1:0]         acc_nx;
    logic [3:0]            flags_nx;
    logic [CNT_W-1:0]      retired_nx;
    logic                  illegal_nx, ir_ld, acc_wr, c_nx, v_nx;
    logic                  mem_we;
    logic [OPND_W-1:0]     mem_wa;
    logic [DW-1:0]         mem_wd;

    assign opcode = ir[DW-1:DW-4];
    assign op     = ir[OPND_W-1:0];
    assign simm   = {{4{op[OPND_W-1]}}, op};
    assign mem_rd = mem[op];
    // immediate forms of ADD/SUB have opcode bit 3 set
    assign opnd_b = opcode[3] ? simm : mem_rd;

    assign add_res    = {1'b0, acc} + {1'b0, opnd_b};
    assign add_ovf    = (acc[DW-1] == opnd_b[DW-1]) && (add_res[DW-1] != acc[DW-1]);
    assign sub_res    = acc - opnd_b;
    assign sub_borrow = acc < opnd_b;
    assign sub_ovf    = (acc[DW-1] != opnd_b[DW-1]) && (sub_res[DW-1] != acc[DW-1]);

    assign halted = (state == S_HALT);

    always_comb begin
        state_nx   = state;
        pc_nx      = pc;
        acc_nx     = acc;
        flags_nx   = flags;
        retired_nx = retired;
        illegal_nx = illegal;
        ir_ld      = 1'b0;
        acc_wr     = 1'b0;
        c_nx       = 1'b0;
        v_nx       = 1'b0;
        mem_we     = 1'b0;
        mem_wa     = load_addr;
        mem_wd     = load_data;
        case (state)
            S_IDLE, S_HALT: begin
                mem_we = load_en;
                if (start) begin
                    state_nx   = S_FETCH;
                    pc_nx      = '0;
                    illegal_nx = 1'b0;
                end
            end
            S_FETCH: begin
                ir_ld    = 1'b1;
                pc_nx    = pc + OPND_W'(1);
                state_nx = S_EXEC;
            end
            S_EXEC: begin
                state_nx   = S_FETCH;
                retired_nx = retired + CNT_W'(1);
                case (opcode)
                    OP_LDA:  begin acc_nx = mem_rd; acc_wr = 1'b1; end
                    OP_LDAI: begin acc_nx = simm;   acc_wr = 1'b1; end
                    OP_STO: begin
                        mem_we = 1'b1;
                        mem_wa = op;
                        mem_wd = acc;
                    end
                    OP_ADD, OP_ADDI: begin
                        acc_nx = add_res[DW-1:0];
                        c_nx   = add_res[DW];
                        v_nx   = add_ovf;
                        acc_wr = 1'b1;
                    end
                    OP_SUB, OP_SUBI: begin
                        acc_nx = sub_res;
                        c_nx   = sub_borrow;
                        v_nx   = sub_ovf;
                        acc_wr = 1'b1;
                    end
                    OP_AND: begin acc_nx = acc & mem_rd; acc_wr = 1'b1; end
                    OP_OR:  begin acc_nx = acc | mem_rd; acc_wr = 1'b1; end
                    OP_JMP: pc_nx = op;
                    OP_JGE: if (!flags[2]) pc_nx = op;
                    OP_JNE: if (!flags[3]) pc_nx = op;
                    OP_STP: state_nx = S_HALT;
                    default: begin
                        state_nx   = S_HALT;
                        illegal_nx = 1'b1;
                        retired_nx = retired;
                    end
                endcase
                if (acc_wr) flags_nx = {acc_nx == '0, acc_nx[DW-1], c_nx, v_nx};
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            pc      <= '0;
            acc     <= '0;
            flags   <= '0;
            retired <= '0;
            illegal <= 1'b0;
            ir      <= '0;
        end else begin
            state   <= state_nx;
            pc      <= pc_nx;
            acc     <= acc_nx;
            flags   <= flags_nx;
            retired <= retired_nx;
            illegal <= illegal_nx;
            if (ir_ld) ir <= mem[pc];
        end
    end

    // memory has no reset; a store racing an asserted reset is dropped
    always_ff @(posedge clk) begin
        if (mem_we && !reset) mem[mem_wa] <= mem_wd;
    end

endmodule

// File: tb/tb_mu02_core.sv
// Bench for mu02_core: instruction-level reference model feeds a scoreboard,
// a monitor compares architectural state whenever the core halts.
module tb_mu02_core;
    localparam int OW = 12;
    localparam int DW = 16;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          load_en = 1'b0;
    logic [OW-1:0] load_addr = '0;
    logic [DW-1:0] load_data = '0;
    logic          halted, illegal;
    logic [OW-1:0] pc;
    logic [DW-1:0] acc;
    logic [3:0]    flags;
    logic [CW-1:0] retired;

    mu02_core #(.OPND_W(OW), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .start(start), .load_en(load_en),
        .load_addr(load_addr), .load_data(load_data), .halted(halted),
        .illegal(illegal), .pc(pc), .acc(acc), .flags(flags), .retired(retired)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;
    int n_done = 0;
    int start_cyc = 0;

    typedef struct {
        logic [DW-1:0] acc;
        logic [3:0]    flags;
        logic [OW-1:0] pc;
        logic [CW-1:0] ret;
        logic          ill;
        int            cycles;
    } exp_t;
    exp_t sbq[$];

    // reference machine state
    logic [DW-1:0] mm [4096];
    logic [DW-1:0] m_acc;
    logic          mz, mn, mc, mv, m_ill;
    int            m_pc;
    logic [CW-1:0] m_ret;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int sgn(input logic [DW-1:0] x);
        return (int'(x) >= 32768) ? int'(x) - 65536 : int'(x);
    endfunction

    function automatic void set_acc(input logic [DW-1:0] v, input logic c, input logic o);
        m_acc = v;
        mz = (v == 16'h0000);
        mn = (sgn(v) < 0);
        mc = c;
        mv = o;
    endfunction

    function automatic void model_reset();
        m_acc = '0; mz = 0; mn = 0; mc = 0; mv = 0; m_ill = 0; m_pc = 0; m_ret = '0;
    endfunction

    // run from current m_pc until halt; returns instructions fetched (incl. the halting one)
    function automatic int mrun();
        int steps = 0;
        int opc, op, s, sv;
        logic [DW-1:0] ir, b, simm;
        while (steps < 10000) begin
            ir = mm[m_pc];
            m_pc = (m_pc + 1) % 4096;
            steps++;
            opc = int'(ir) / 4096;
            op = int'(ir) % 4096;
            simm = (op >= 2048) ? DW'(op - 4096) : DW'(op);
            if (opc == 7) begin m_ret++; m_ill = 0; return steps; end
            if (opc == 9 || opc >= 14) begin m_ill = 1; return steps; end
            case (opc)
                0: set_acc(mm[op], 0, 0);
                8: set_acc(simm, 0, 0);
                1: mm[op] = m_acc;
                2, 10: begin
                    b = (opc == 2) ? mm[op] : simm;
                    s = int'(m_acc) + int'(b);
                    sv = sgn(m_acc) + sgn(b);
                    set_acc(DW'(s), s > 65535, sv > 32767 || sv < -32768);
                end
                3, 11: begin
                    b = (opc == 3) ? mm[op] : simm;
                    s = int'(m_acc) - int'(b);
                    sv = sgn(m_acc) - sgn(b);
                    set_acc(DW'(s), int'(m_acc) < int'(b), sv > 32767 || sv < -32768);
                end
                12: set_acc(m_acc & mm[op], 0, 0);
                13: set_acc(m_acc | mm[op], 0, 0);
                4: m_pc = op;
                5: if (!mn) m_pc = op;
                6: if (!mz) m_pc = op;
                default: ;
            endcase
            m_ret++;
        end
        return steps;
    endfunction

    // monitor: every rising halted pops one expectation
    initial begin
        logic prev_h = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (halted && !prev_h) begin
                if (sbq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_halt: halted=1 with no expectation queued");
                end else begin
                    e = sbq.pop_front();
                    chk("acc", 32'(acc), 32'(e.acc));
                    chk("flags", 32'(flags), 32'(e.flags));
                    chk("pc", 32'(pc), 32'(e.pc));
                    chk("retired", retired, e.ret);
                    chk("illegal", 32'(illegal), 32'(e.ill));
                    chk("cycles", 32'(cyc - start_cyc), 32'(e.cycles));
                end
                n_done++;
            end
            prev_h = halted;
        end
    end

    task automatic do_load(input int a, input logic [DW-1:0] d);
        @(negedge clk);
        load_en = 1'b1; load_addr = OW'(a); load_data = d;
        mm[a] = d;
        @(posedge clk); #1;
        load_en = 1'b0;
    endtask

    // optional load in the start cycle; optional disturbance (load/start) while running
    task automatic run_prog(input bit with_load, input int la, input logic [DW-1:0] ld,
                            input bit disturb);
        exp_t e;
        int n, n0;
        if (with_load) mm[la] = ld;
        m_pc = 0; m_ill = 0;
        n = mrun();
        e.acc = m_acc; e.flags = {mz, mn, mc, mv}; e.pc = OW'(m_pc);
        e.ret = m_ret; e.ill = m_ill; e.cycles = 2 * n;
        sbq.push_back(e);
        n0 = n_done;
        @(negedge clk);
        start = 1'b1;
        if (with_load) begin load_en = 1'b1; load_addr = OW'(la); load_data = ld; end
        @(posedge clk); #1;
        start = 1'b0; load_en = 1'b0;
        start_cyc = cyc;
        if (disturb) begin
            @(negedge clk);
            start = 1'b1; load_en = 1'b1; load_addr = 12'h003; load_data = 16'hF000;
            @(posedge clk); #1;
            start = 1'b0; load_en = 1'b0;
        end
        for (int i = 0; i < 2 * n + 50; i++) begin
            @(posedge clk); #2;
            if (n_done != n0) return;
        end
        total++; bad++;
        $display("FAIL halt_timeout: no halt within %0d cycles", 2 * n + 50);
        sbq.delete();
    endtask

    initial begin
        int len, opc;
        logic [DW-1:0] w;
        int opcs[12] = '{0, 8, 1, 2, 10, 3, 11, 12, 13, 4, 5, 6};

        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("rst_pc", 32'(pc), 0);
        chk("rst_acc", 32'(acc), 0);
        chk("rst_flags", 32'(flags), 0);
        chk("rst_retired", retired, 0);
        chk("rst_halted", 32'(halted), 0);
        chk("rst_illegal", 32'(illegal), 0);

        for (int a = 0; a < 4096; a++) do_load(a, 16'h0000);

        // countdown, with load/start pulses while running that must be ignored
        do_load(0, 16'h8003); do_load(1, 16'hB001); do_load(2, 16'h6001); do_load(3, 16'h7000);
        run_prog(0, 0, 0, 1);

        // signed overflow on ADD, then on SUBI
        do_load(16'h010, 16'h7FFF); do_load(16'h011, 16'h0001);
        do_load(0, 16'h0010); do_load(1, 16'h2011); do_load(2, 16'h1012); do_load(3, 16'h7000);
        run_prog(0, 0, 0, 0);
        do_load(0, 16'h0012); do_load(1, 16'hB001); do_load(2, 16'h7000);
        run_prog(0, 0, 0, 0);

        // carry out, JGE taken then not taken
        do_load(0, 16'h8FFF); do_load(1, 16'hA001); do_load(2, 16'h5020);
        do_load(16'h020, 16'h8800); do_load(16'h021, 16'h5030); do_load(16'h022, 16'h7000);
        do_load(16'h030, 16'h7000);
        run_prog(0, 0, 0, 0);

        // illegal trap, then load+start in the same cycle replaces it with STP
        do_load(0, 16'hF000);
        run_prog(0, 0, 0, 0);
        run_prog(1, 0, 16'h7000, 0);

        // pc wrap at FFF; self-modified word at 000 is STP on refetch
        do_load(16'h100, 16'h7000); do_load(0, 16'h0100); do_load(1, 16'h1000);
        do_load(2, 16'h4FFF); do_load(16'hFFF, 16'h8005);
        run_prog(0, 0, 0, 0);

        // reset during EXEC of STO 050
        do_load(16'h101, 16'h1234); do_load(16'h050, 16'hABCD);
        do_load(0, 16'h0101); do_load(1, 16'h1050); do_load(2, 16'h7000);
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); reset = 1'b1;
        @(posedge clk);
        @(negedge clk); reset = 1'b0;
        model_reset();
        chk("mid_rst_halted", 32'(halted), 0);
        chk("mid_rst_acc", 32'(acc), 0);
        chk("mid_rst_flags", 32'(flags), 0);
        chk("mid_rst_retired", retired, 0);
        chk("mid_rst_pc", 32'(pc), 0);
        do_load(0, 16'h0050); do_load(1, 16'h7000);
        run_prog(0, 0, 0, 0);

        // random straight-line/forward-branch programs
        for (int t = 0; t < 16; t++) begin
            for (int d = 0; d < 16; d++) do_load(16'h100 + d, DW'($urandom));
            len = $urandom_range(4, 14);
            for (int i = 0; i < len; i++) begin
                opc = opcs[$urandom_range(0, 11)];
                case (opc)
                    0, 1, 2, 3, 12, 13: w = DW'(opc * 4096 + 16'h100 + $urandom_range(0, 15));
                    4, 5, 6:            w = DW'(opc * 4096 + $urandom_range(i + 1, len));
                    default:            w = DW'(opc * 4096 + $urandom_range(0, 4095));
                endcase
                do_load(i, w);
            end
            do_load(len, 16'h7000);
            run_prog(0, 0, 0, 0);
        end

        repeat (4) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
